// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between write-back requesters.
// Grants are combinational; the register file sees a registered rd/data/writeEn stage.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [XLEN*NREQ-1:0] req_data,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 wb_en,
    output logic [1:0]           grant_id,
    output logic [15:0]          wr_count
);

    typedef enum logic {IDLE, WRITE} stateT;

    stateT             state;
    stateT             nextState;
    logic [1:0]        ptr;
    logic [NREQ-1:0]   grantVec;
    logic [1:0]        grantIdx;
    logic              grantFound;
    logic [2:0]        cand;
    logic [4:0]        selRd;
    logic [XLEN-1:0]   selData;
    logic              transfer;
    logic              commit;

    // Search ptr, ptr+1, ... (mod NREQ) and take the first valid requester.
    always_comb begin
        grantVec   = '0;
        grantIdx   = '0;
        grantFound = 1'b0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!grantFound && req_valid[cand[1:0]]) begin
                grantVec[cand[1:0]] = 1'b1;
                grantIdx            = cand[1:0];
                grantFound          = 1'b1;
            end
        end
    end

    always_comb begin
        selRd   = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantVec[i]) begin
                selRd   = req_rd[5*i +: 5];
                selData = req_data[XLEN*i +: XLEN];
            end
        end
    end

    assign req_ready = (hold || r) ? '0 : grantVec;
    assign transfer  = |req_ready;
    assign commit    = transfer && (selRd != 5'd0);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Both states leave toward WRITE only when a non-x0 write is accepted this cycle.
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = commit ? WRITE : IDLE;
            WRITE:   nextState = commit ? WRITE : IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign wb_en = (state == WRITE);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            ptr      <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            grant_id <= '0;
            wr_count <= '0;
        end else begin
            if (transfer) begin
                ptr      <= (grantIdx == 2'(NREQ-1)) ? 2'd0 : grantIdx + 2'd1;
                grant_id <= grantIdx;
            end
            if (commit) begin
                wb_rd   <= selRd;
                wb_data <= selData;
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

endmodule
